// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence detector front end.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_t;

  localparam int unsigned SEQ_WORD_W = 8;

endpackage

// File: rtl/word_hold_buf.sv
// One-entry word buffer with full flag; load fills it, unload empties it.
module word_hold_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready and emits them
// one bit per bit_en on x, with a one-word hold buffer for gapless streaming.
module serial_bit_feeder
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = SEQ_WORD_W,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  feeder_state_t    state, state_next;
  logic [WIDTH-1:0] sr, sr_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full;
  logic             hold_load, hold_unload;
  logic             hs, last_bit, out_next;

  assign din_ready = ~hold_full;
  assign busy      = x_valid | hold_full;
  assign hs        = din_valid & ~hold_full;
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

  word_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .reset  (reset),
    .load   (hold_load),
    .unload (hold_unload),
    .d      (din),
    .q      (hold_q),
    .full   (hold_full)
  );

  // Next-state, shifter and hold-buffer control
  always_comb begin
    state_next  = state;
    sr_next     = sr;
    cnt_next    = cnt;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    case (state)
      IDLE: begin
        if (hs) begin
          sr_next    = din;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en && !last_bit) begin
          sr_next   = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
          cnt_next  = cnt + CNT_W'(1);
          hold_load = hs;
        end else if (bit_en) begin
          // Last bit consumed: a held word wins over a fresh handshake
          if (hold_full) begin
            sr_next     = hold_q;
            cnt_next    = '0;
            hold_unload = 1'b1;
          end else if (hs) begin
            sr_next  = din;
            cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          hold_load = hs;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_next = MSB_FIRST ? sr_next[WIDTH-1] : sr_next[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
    end else begin
      state   <= state_next;
      sr      <= sr_next;
      cnt     <= cnt_next;
      x       <= (state_next == SHIFT) ? out_next : IDLE_BIT;
      x_valid <= (state_next == SHIFT);
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder: expected bits are queued on acceptance
// and a negedge monitor compares them against x whenever x_valid is high.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din, l_din;
  logic       din_valid, l_valid, bit_en;
  logic       din_ready, x, x_valid, busy;
  logic       l_ready, l_x, l_x_valid, l_busy;

  int n_checks = 0;
  int n_err    = 0;
  bit q_m[$];
  bit q_l[$];

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .bit_en(bit_en), .x(x), .x_valid(x_valid), .busy(busy)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .din(l_din), .din_valid(l_valid), .din_ready(l_ready),
    .bit_en(bit_en), .x(l_x), .x_valid(l_x_valid), .busy(l_busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msb(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q_m.push_back(w[i]);
  endtask

  task automatic push_lsb(input logic [7:0] w);
    for (int i = 0; i < 8; i++) q_l.push_back(w[i]);
  endtask

  // Monitor: a valid bit must match the queue head; it is retired when consumed
  always @(negedge clk) begin
    if (!reset) begin
      if (x_valid) begin
        if (q_m.size() == 0) check("msb_extra_bit", 1, 0);
        else begin
          check("msb_bit", int'(x), int'(q_m[0]));
          if (bit_en) void'(q_m.pop_front());
        end
      end else begin
        check("msb_idle_x", int'(x), 0);
      end
      if (l_x_valid) begin
        if (q_l.size() == 0) check("lsb_extra_bit", 1, 0);
        else begin
          check("lsb_bit", int'(l_x), int'(q_l[0]));
          if (bit_en) void'(q_l.pop_front());
        end
      end
    end
  end

  initial begin
    int vcnt, rlow, gaps, acc, cyc;
    bit seen_end, hs;
    reset = 1'b1; din = '0; din_valid = 1'b0; l_din = '0; l_valid = 1'b0; bit_en = 1'b1;
    tick();
    tick();
    check("rst_x", int'(x), 0);
    check("rst_x_valid", int'(x_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_din_ready", int'(din_ready), 1);
    reset = 1'b0;
    tick();

    // Single word B4
    din = 8'hB4; din_valid = 1'b1; push_msb(8'hB4);
    tick();
    din_valid = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (x_valid) vcnt++;
      tick();
    end
    check("single_valid_cycles", vcnt, 8);
    check("single_end_busy", int'(busy), 0);

    // Back-to-back B4 then 0F
    din = 8'hB4; din_valid = 1'b1; push_msb(8'hB4);
    tick();
    vcnt = int'(x_valid);
    din = 8'h0F; push_msb(8'h0F);
    tick();
    din_valid = 1'b0;
    check("b2b_ready_low", int'(din_ready), 0);
    check("b2b_busy", int'(busy), 1);
    rlow = 0; gaps = 0; seen_end = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (x_valid) begin
        vcnt++;
        if (seen_end) gaps++;
      end else seen_end = 1'b1;
      if (!din_ready) rlow++;
      tick();
    end
    check("b2b_valid_cycles", vcnt, 16);
    check("b2b_ready_low_cycles", rlow, 7);
    check("b2b_gaps", gaps, 0);

    // Stall: bit_en alternating 0/1
    din = 8'hB4; din_valid = 1'b1; push_msb(8'hB4);
    tick();
    din_valid = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 24; i++) begin
      bit_en = (i % 2) == 1;
      #0;
      if (x_valid) vcnt++;
      tick();
    end
    bit_en = 1'b1;
    check("stall_valid_cycles", vcnt, 16);

    // LSB first, word 01
    l_din = 8'h01; l_valid = 1'b1; push_lsb(8'h01);
    tick();
    l_valid = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (l_x_valid) vcnt++;
      tick();
    end
    check("lsb_valid_cycles", vcnt, 8);

    // Reset mid-word with FF held
    din = 8'hB4; din_valid = 1'b1; push_msb(8'hB4);
    tick();
    din = 8'hFF;
    tick();
    din_valid = 1'b0;
    check("rst_mid_hold_full", int'(din_ready), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    q_m.delete();
    check("rstmid_x", int'(x), 0);
    check("rstmid_x_valid", int'(x_valid), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_din_ready", int'(din_ready), 1);
    reset = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (x_valid) vcnt++;
      tick();
    end
    check("rstmid_no_resume", vcnt, 0);

    // Hold priority: held 0F beats waiting A5 on the last-bit edge
    din = 8'hB4; din_valid = 1'b1; push_msb(8'hB4);
    tick();
    vcnt = int'(x_valid);
    din = 8'h0F; push_msb(8'h0F);
    tick();
    din = 8'hA5;
    cyc = 2; acc = 0; gaps = 0; seen_end = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (x_valid) begin
        vcnt++;
        if (seen_end) gaps++;
      end else seen_end = 1'b1;
      hs = din_valid && din_ready;
      if (hs) begin
        push_msb(8'hA5);
        acc = cyc;
      end
      tick();
      cyc++;
      if (hs) din_valid = 1'b0;
    end
    din_valid = 1'b0;
    check("prio_accept_cycle", acc, 9);
    check("prio_valid_cycles", vcnt, 24);
    check("prio_gaps", gaps, 0);

    tick();
    check("msb_queue_drained", q_m.size(), 0);
    check("lsb_queue_drained", q_l.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
